// File: rtl/img_pixel_proc.sv
// Streaming RGB point-operation processor: one pixel per beat in, one register stage out, raster coordinates and frame-done pulse.
// Optional grayscale mode 5 is built only when IMG_PROC_GRAY_EN is defined.
module img_pixel_proc #(
    parameter int WIDTH     = 768,
    parameter int HEIGHT    = 512,
    parameter int DW        = 8,
    parameter int VALUE     = 100,
    parameter int THRESHOLD = 90,
    localparam int CW = $clog2(WIDTH),
    localparam int RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1
) (
    input  logic          HCLK,
    input  logic          HRESET,
    input  logic          start,
    input  logic [2:0]    sel,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_r,
    input  logic [DW-1:0] in_g,
    input  logic [DW-1:0] in_b,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_r,
    output logic [DW-1:0] out_g,
    output logic [DW-1:0] out_b,
    output logic [CW-1:0] out_col,
    output logic [RW-1:0] out_row,
    output logic          busy,
    output logic          ctrl_done,
    output logic [1:0]    fsm_state
);

    // Handshake: a beat transfers on the rising edge where valid & ready are both high;
    // a producer holds valid and data steady until that edge, and ready never depends on valid.
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

    localparam int N   = WIDTH * HEIGHT;
    localparam int NCW = $clog2(N + 1);
    localparam logic [DW:0]   VAL_EXT = (DW+1)'(VALUE);
    localparam logic [DW-1:0] VAL_DW  = DW'(VALUE);
    localparam logic [DW+1:0] THR3    = (DW+2)'(3 * THRESHOLD);
    localparam logic [DW-1:0] MAXV    = '1;

    state_t         state;
    logic [2:0]     mode_q;
    logic [NCW-1:0] in_cnt;
    logic           last_in_taken;
    logic           in_fire;
    logic           out_fire;
    logic           last_beat;
    logic [DW-1:0]  nxt_r, nxt_g, nxt_b;
    logic [DW+1:0]  sum_rgb;

    assign fsm_state     = state;
    assign last_in_taken = (in_cnt == NCW'(N));
    assign in_ready      = (state == RUN) && (!out_valid || out_ready) && !last_in_taken;
    assign in_fire       = in_valid && in_ready;
    assign out_fire      = out_valid && out_ready;
    assign last_beat     = out_fire && (out_col == CW'(WIDTH - 1)) && (out_row == RW'(HEIGHT - 1));
    assign sum_rgb       = {2'b00, in_r} + {2'b00, in_g} + {2'b00, in_b};

`ifdef IMG_PROC_GRAY_EN
    logic [DW+1:0] gray_sum;
    logic [DW-1:0] gray_y;
    assign gray_sum = {2'b00, in_r} + {1'b0, in_g, 1'b0} + {2'b00, in_b};
    assign gray_y   = gray_sum[DW+1:2];
`endif

    function automatic logic [DW-1:0] bright_up(input logic [DW-1:0] p);
        logic [DW:0] s;
        s = {1'b0, p} + VAL_EXT;
        return s[DW] ? MAXV : s[DW-1:0];
    endfunction

    function automatic logic [DW-1:0] bright_dn(input logic [DW-1:0] p);
        return (p > VAL_DW) ? (p - VAL_DW) : '0;
    endfunction

    always_comb begin
        nxt_r = in_r;
        nxt_g = in_g;
        nxt_b = in_b;
        case (mode_q)
            3'd1: begin
                nxt_r = bright_up(in_r);
                nxt_g = bright_up(in_g);
                nxt_b = bright_up(in_b);
            end
            3'd2: begin
                nxt_r = bright_dn(in_r);
                nxt_g = bright_dn(in_g);
                nxt_b = bright_dn(in_b);
            end
            3'd3: begin
                nxt_r = MAXV - in_r;
                nxt_g = MAXV - in_g;
                nxt_b = MAXV - in_b;
            end
            3'd4: begin
                nxt_r = (sum_rgb > THR3) ? MAXV : '0;
                nxt_g = (sum_rgb > THR3) ? MAXV : '0;
                nxt_b = (sum_rgb > THR3) ? MAXV : '0;
            end
`ifdef IMG_PROC_GRAY_EN
            3'd5: begin
                nxt_r = gray_y;
                nxt_g = gray_y;
                nxt_b = gray_y;
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state     <= IDLE;
            mode_q    <= 3'd0;
            in_cnt    <= '0;
            out_valid <= 1'b0;
            out_r     <= '0;
            out_g     <= '0;
            out_b     <= '0;
            out_col   <= '0;
            out_row   <= '0;
            busy      <= 1'b0;
            ctrl_done <= 1'b0;
        end else begin
            ctrl_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= RUN;
                        mode_q  <= sel;
                        in_cnt  <= '0;
                        out_col <= '0;
                        out_row <= '0;
                        busy    <= 1'b1;
                    end
                end
                RUN: begin
                    if (in_fire) begin
                        out_r  <= nxt_r;
                        out_g  <= nxt_g;
                        out_b  <= nxt_b;
                        in_cnt <= in_cnt + NCW'(1);
                    end
                    // Reload takes priority so accept-out plus accept-in leaves no bubble.
                    if (in_fire)
                        out_valid <= 1'b1;
                    else if (out_fire)
                        out_valid <= 1'b0;
                    if (out_fire) begin
                        if (out_col == CW'(WIDTH - 1)) begin
                            out_col <= '0;
                            out_row <= (out_row == RW'(HEIGHT - 1)) ? '0 : out_row + RW'(1);
                        end else begin
                            out_col <= out_col + CW'(1);
                        end
                    end
                    if (last_beat) begin
                        state     <= DONE;
                        ctrl_done <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
